ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit directly upstream of the decode stage.
- Holds the architectural PC and issues word fetches to instruction memory over a valid/ready request channel plus a response channel.
- Presents each fetched instruction and its PC to decode with a valid/ready handshake.
- Takes the next PC from decode's jump/jump_addr redirect, or PC+4, and stops fetching when decode signals ebreak.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; the first fetch address.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  fetch address; equals pc.
- imem_rsp_valid  in  1  fetch data valid.
- imem_rsp_data  in  32  fetched instruction word.
- inst_valid  out  1  inst and inst_pc are valid for decode.
- inst_ready  in  1  decode consumes the instruction this cycle.
- inst  out  32  instruction to decode.
- inst_pc  out  32  PC of inst.
- jump  in  1  redirect from decode; sampled only at handoff.
- jump_addr  in  32  redirect target.
- halt  in  1  decode stop (ebreak); sampled only at handoff.
- halted  out  1  fetch permanently stopped.
- fetch_err  out  1  sticky misaligned-target error.
- inst_count  out  32  number of instructions handed to decode.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC, state=REQ.
  - inst=0, inst_pc=0, inst_valid=0, halted=0, fetch_err=0, inst_count=0.
  - imem_req_valid=0 during the reset cycle.
  - Reset mid-operation abandons any transaction. Instruction memory shares rst, so no stale response arrives afterwards.
- States:
  - REQ: imem_req_valid=1, imem_req_addr=pc. If imem_req_ready, go to WAIT.
  - WAIT: imem_req_valid=0. imem_rsp_valid is ignored in every state except WAIT. On imem_rsp_valid: inst<=imem_rsp_data, inst_pc<=pc, go to HOLD.
  - HOLD: inst_valid=1; inst and inst_pc stay stable until the handoff. Handoff = inst_valid & inst_ready. On handoff:
    - inst_count increments; it wraps 32'hFFFF_FFFF to 0.
    - If halt: go to HALT; pc is unchanged.
    - Else pc<=(jump ? jump_addr : pc+PC_STEP), go to REQ.
    - Arithmetic is 32-bit modulo, so pc=32'hFFFF_FFFC steps to 0.
  - HALT: no requests, inst_valid=0, halted=1. Only rst exits.
  - ERR (macro only): same as HALT but fetch_err=1, halted=1.
- halt and jump asserted together: halt wins; no redirect occurs.
- jump/halt outside a handoff cycle are ignored.
- Throughput: with zero-wait memory (ready=1, response the next cycle), one instruction per 3 cycles (REQ, WAIT, HOLD).
  - Example: the first inst_valid rises 2 cycles after the first REQ cycle.
- inst_valid is registered: it rises the cycle after response capture and falls the cycle after handoff.

Optional Feature:
- Macro: IFU_MISALIGN_CHECK_EN.
- Defined: at a handoff with jump=1 and jump_addr[1:0]!=0 (and halt=0):
  - Go to ERR; pc<=jump_addr is recorded for debug.
  - fetch_err=1 is sticky until rst; no further requests.
- Undefined:
  - fetch_err is tied to 0.
  - The redirect loads {jump_addr[31:2],2'b00}, silently aligning the target.

Test Plan:
- Reset, then zero-wait memory returning 32'h00000013 at every address, inst_ready=1 -> imem_req_addr is 8000_0000, 8000_0004, 8000_0008. inst_pc tracks the address. inst_count=3 after 9 cycles post-reset.
- Handoff of inst_pc=8000_0004 with jump=1, jump_addr=8000_0100 -> next imem_req_addr=8000_0100, and the next inst_pc=8000_0100.
- imem_req_ready held low 5 cycles, then imem_rsp_valid delayed 3 cycles -> request is held stable with addr unchanged; inst_valid rises the cycle after the response; no duplicate request.
- inst_ready low 4 cycles while inst_valid=1 -> inst/inst_pc stable; no new request; inst_count unchanged until handoff.
- halt=1 and jump=1 at the same handoff -> halted=1, imem_req_valid stays 0, pc unchanged. Asserting rst -> next request to 8000_0000, halted=0.
- Misaligned redirect: jump_addr=8000_0102.
  - With IFU_MISALIGN_CHECK_EN: fetch_err=1, no further requests.
  - Without it: next imem_req_addr=8000_0100, fetch_err=0.

Source files
------------

// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch -- instruction fetch unit feeding the decode stage.
//
// Holds the architectural PC. Issues one word fetch at a time over a
// valid/ready request channel and waits on the response channel. Each fetched
// word goes to decode through a valid/ready handshake together with its PC.
// At the handoff the next PC is taken from decode's redirect (jump/jump_addr)
// or is pc + PC_STEP. When decode signals halt (ebreak), fetching stops until
// reset.
//
// Ports:
//   clk, rst          core clock; synchronous active-high reset
//   imem_req_valid    fetch request valid (REQ state only)
//   imem_req_ready    memory accepts the request this cycle
//   imem_req_addr     fetch address, always equal to pc
//   imem_rsp_valid    fetch data valid (honoured only while waiting)
//   imem_rsp_data     fetched instruction word
//   inst_valid        inst / inst_pc hold a word for decode (registered)
//   inst_ready        decode consumes the word this cycle
//   inst, inst_pc     instruction word and its PC
//   jump, jump_addr   redirect from decode, sampled only at the handoff
//   halt              stop request from decode, sampled only at the handoff
//   halted            fetch permanently stopped
//   fetch_err         sticky misaligned-redirect error
//   inst_count        number of words handed to decode (wraps)
//
// Build option:
//   IFU_MISALIGN_CHECK_EN -- if defined, a redirect to a target that is not
//   word aligned stops fetch in an error state and raises fetch_err. If not
//   defined, fetch_err is tied low and the target's low two bits are dropped.
// ----------------------------------------------------------------------------
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  input  logic        halt,
  output logic        halted,
  output logic        fetch_err,
  output logic [31:0] inst_count
);

  localparam logic [2:0] S_REQ  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_HALT = 3'd3;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam logic [2:0] S_ERR  = 3'd4;
`endif

  logic [2:0]  state;
  logic [31:0] pc;
  logic        handoff;

  // Force a redirect target onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Sequential or redirected successor PC; arithmetic wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] cur,
                                          input logic        redirect,
                                          input logic [31:0] target);
    return redirect ? align_word(target) : cur + PC_STEP;
  endfunction

`ifdef IFU_MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction
`endif

  assign handoff = inst_valid & inst_ready;

  // The request is gated by rst so nothing is offered during a reset cycle,
  // even when the state register still holds REQ from before the reset.
  assign imem_req_valid = (state == S_REQ) & ~rst;
  assign imem_req_addr  = pc;

`ifdef IFU_MISALIGN_CHECK_EN
  assign halted    = (state == S_HALT) | (state == S_ERR);
  assign fetch_err = (state == S_ERR);
`else
  assign halted    = (state == S_HALT);
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      inst_count <= '0;
    end else begin
      case (state)
        // request stage: hold address until memory accepts it
        S_REQ: begin
          if (imem_req_ready) begin
            state <= S_WAIT;
          end
        end
        // response stage: capture the word; inst_valid is registered here
        S_WAIT: begin
          if (imem_rsp_valid) begin
            inst       <= imem_rsp_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= S_HOLD;
          end
        end
        // decode handoff stage: halt has priority over any redirect
        S_HOLD: begin
          if (handoff) begin
            inst_valid <= 1'b0;
            inst_count <= inst_count + 32'd1;
            if (halt) begin
              state <= S_HALT;
`ifdef IFU_MISALIGN_CHECK_EN
            end else if (jump && misaligned(jump_addr)) begin
              // Raw target kept in pc so the faulting address is visible.
              pc    <= jump_addr;
              state <= S_ERR;
`endif
            end else begin
              pc    <= next_pc(pc, jump, jump_addr);
              state <= S_REQ;
            end
          end
        end
        // HALT and ERR are terminal until reset
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// ----------------------------------------------------------------------------
// tb_ifu_fetch -- scoreboard bench for ifu_fetch.
//
// The stimulus process pushes the expected fetch addresses and the expected
// (pc, instruction) pairs into queues; two monitors pop and compare whenever
// the DUT completes a memory request or a decode handoff. A behavioural memory
// answers each accepted request after rsp_delay extra cycles with the word
// {addr[15:0], 16'h0013}. Optional build: IFU_MISALIGN_CHECK_EN.
// ----------------------------------------------------------------------------
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        jump;
  logic [31:0] jump_addr;
  logic        halt;
  logic        halted;
  logic        fetch_err;
  logic [31:0] inst_count;

  int          checks = 0;
  int          errors = 0;
  int          rsp_delay = 0;
  logic [31:0] req_q[$];
  logic [63:0] inst_q[$];

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .jump          (jump),
    .jump_addr     (jump_addr),
    .halt          (halt),
    .halted        (halted),
    .fetch_err     (fetch_err),
    .inst_count    (inst_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], 16'h0013};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] addr, input logic [31:0] word);
    req_q.push_back(addr);
    inst_q.push_back({addr, word});
  endtask

  // Wait (bounded) for a decode-side word with the given PC.
  task automatic wait_hold(input logic [31:0] pc, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(inst_valid && inst_pc == pc) && n < 60);
    check(name, {31'd0, inst_valid && inst_pc == pc}, 32'd1);
  endtask

  // Memory model: one outstanding request, answered after rsp_delay cycles.
  initial begin
    logic        fire;
    logic        pending;
    logic [31:0] a;
    logic [31:0] pend_addr;
    int          cnt;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pending        = 1'b0;
    pend_addr      = '0;
    cnt            = 0;
    forever begin
      @(negedge clk);
      fire = imem_req_valid && imem_req_ready;
      a    = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (fire) begin
        pending   = 1'b1;
        pend_addr = a;
        cnt       = rsp_delay;
      end
      if (pending) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pending        = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Request monitor.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %h expected no request", imem_req_addr);
        end else begin
          exp = req_q.pop_front();
          check("req_addr", imem_req_addr, exp);
        end
      end
    end
  end

  // Decode handoff monitor.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        if (inst_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_handoff: got pc %h expected no handoff", inst_pc);
        end else begin
          exp = inst_q.pop_front();
          check("handoff_pc", inst_pc, exp[63:32]);
          check("handoff_inst", inst, exp[31:0]);
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    jump = 1'b0; jump_addr = '0; halt = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    check("rst_count", inst_count, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_pc", imem_req_addr, 32'h8000_0000);
    @(posedge clk); #1;
    rst = 1'b0;

    // Sequential fetch, then a redirect at the handoff of 8000_0004
    expect_fetch(32'h8000_0000, 32'h0000_0013);
    expect_fetch(32'h8000_0004, 32'h0004_0013);
    expect_fetch(32'h8000_0100, 32'h0100_0013);
    wait_hold(32'h8000_0004, "reach_pc4");
    jump = 1'b1; jump_addr = 32'h8000_0100;
    @(posedge clk); #1;
    jump = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    rsp_delay = 3;
    expect_fetch(32'h8000_0104, 32'h0104_0013);

    // Memory not ready for 5 cycles: request held stable
    @(negedge clk);
    check("count_after_9", inst_count, 32'd3);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("stall_req_addr", imem_req_addr, 32'h8000_0104);
    end
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b0;

    // Response delayed by 3 cycles
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!imem_rsp_valid && n < 30);
    check("rsp_seen", {31'd0, imem_rsp_valid}, 32'd1);
    check("iv_at_rsp", {31'd0, inst_valid}, 32'd0);
    check("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk);

    // Decode stalled for 4 cycles
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      check("hold_valid", {31'd0, inst_valid}, 32'd1);
      check("hold_pc", inst_pc, 32'h8000_0104);
      check("hold_inst", inst, 32'h0104_0013);
      check("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
      check("hold_count", inst_count, 32'd3);
    end
    @(posedge clk); #1;
    inst_ready = 1'b1;
    rsp_delay = 0;
    expect_fetch(32'h8000_0108, 32'h0108_0013);

    // halt and jump together: halt wins, pc unchanged
    wait_hold(32'h8000_0108, "reach_pc108");
    halt = 1'b1; jump = 1'b1; jump_addr = 32'h8000_0200;
    @(posedge clk); #1;
    halt = 1'b0; jump = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_halted", {31'd0, halted}, 32'd1);
      check("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
      check("halt_no_inst", {31'd0, inst_valid}, 32'd0);
      check("halt_pc", imem_req_addr, 32'h8000_0108);
      check("halt_count", inst_count, 32'd5);
    end

    // Reset exits HALT
    @(posedge clk); #1;
    rst = 1'b1;
    expect_fetch(32'h8000_0000, 32'h0000_0013);
    expect_fetch(32'hFFFF_FFFC, 32'hFFFC_0013);
    expect_fetch(32'h0000_0000, 32'h0000_0013);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rerst_halted", {31'd0, halted}, 32'd0);
    check("rerst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("rerst_addr", imem_req_addr, 32'h8000_0000);
    check("rerst_count", inst_count, 32'd0);

    // Redirect to the top word: pc wraps to 0
    wait_hold(32'h8000_0000, "reach_rst_pc");
    jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    jump = 1'b0;

    // Misaligned redirect
    wait_hold(32'h0000_0000, "reach_wrap_pc");
    jump = 1'b1; jump_addr = 32'h8000_0102;
    @(posedge clk); #1;
    jump = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mis_fetch_err", {31'd0, fetch_err}, 32'd1);
      check("mis_halted", {31'd0, halted}, 32'd1);
      check("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
      check("mis_pc", imem_req_addr, 32'h8000_0102);
    end
`else
    req_q.push_back(32'h8000_0100);
    inst_ready = 1'b0;
    @(negedge clk);
    check("mis_fetch_err", {31'd0, fetch_err}, 32'd0);
    check("mis_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("mis_aligned_addr", imem_req_addr, 32'h8000_0100);
    wait_hold(32'h8000_0100, "reach_aligned");
    check("mis_inst", inst, 32'h0100_0013);
    check("mis_fetch_err_hold", {31'd0, fetch_err}, 32'd0);
`endif

    @(negedge clk);
    check("req_q_drained", req_q.size(), 32'd0);
    check("inst_q_drained", inst_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish before 20000");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
